// File: rtl/bus_memory8227.sv
// Memory responder for the 8227 CPU bus: low RAM, program RAM window, interrupt/reset vectors and a back-door loader.
// Optional wait-state tracker is compiled in when BUS_WAIT_STATES_EN is defined.
module bus_memory8227 #(
   parameter int          LOW_BITS    = 11,
   parameter logic [15:0] PROG_BASE   = 16'hCC00,
   parameter int          PROG_BITS   = 8,
   parameter logic [15:0] NMI_VEC     = 16'h0000,
   parameter logic [15:0] RST_VEC     = 16'hCCDD,
   parameter logic [15:0] IRQ_VEC     = 16'h0000,
   parameter int          WAIT_STATES = 0,
   parameter logic [7:0]  OPEN_BUS    = 8'hFF
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [7:0]  AddressBusHigh,
   input  logic [7:0]  AddressBusLow,
   input  logic        readNotWrite,
   input  logic [7:0]  dataBusOutput,
   input  logic        dataBusEnable,
   output logic [7:0]  dataBusInput,
   output logic        ready,
   input  logic        load_en,
   input  logic [15:0] load_addr,
   input  logic [7:0]  load_data
);

   localparam int          LOW_SIZE  = 2 ** LOW_BITS;
   localparam int          PROG_SIZE = 2 ** PROG_BITS;
   localparam logic [16:0] PROG_END  = {1'b0, PROG_BASE} + 17'(PROG_SIZE);

   if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_wait_states
      $error("WAIT_STATES must be in 0..7");
   end
   if ((PROG_BASE % PROG_SIZE) != 0) begin : g_bad_prog_base
      $error("PROG_BASE must be aligned to the program RAM size");
   end

   typedef enum logic [1:0] {
      REG_NONE,
      REG_LOW,
      REG_PROG,
      REG_VEC
   } region_t;

   // Vectors win over the program window so 0xFFFA..0xFFFF never alias program RAM.
   function automatic region_t decode(input logic [15:0] a);
      if (a >= 16'hFFFA) return REG_VEC;
      if ({1'b0, a} < 17'(LOW_SIZE)) return REG_LOW;
      if (a >= PROG_BASE && {1'b0, a} < PROG_END) return REG_PROG;
      return REG_NONE;
   endfunction

   function automatic logic [2:0] vec_index(input logic [15:0] a);
      return a[2:0] - 3'd2;
   endfunction

   logic [15:0] addr;
   region_t     rd_region;
   region_t     wr_region;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        cpu_we;
   logic        wr_en;

   assign addr      = {AddressBusHigh, AddressBusLow};
   assign rd_region = decode(addr);

   // ready is low whenever the loader strobes, so the shared write port never sees two writers.
   assign wr_addr   = load_en ? load_addr : addr;
   assign wr_data   = load_en ? load_data : dataBusOutput;
   assign wr_region = decode(wr_addr);
   assign cpu_we    = !readNotWrite && dataBusEnable && ready;
   assign wr_en     = load_en || cpu_we;

   logic [7:0] low_mem  [LOW_SIZE];
   logic [7:0] prog_mem [PROG_SIZE];
   logic [7:0] vec_mem  [6];

   always_comb begin
      dataBusInput = OPEN_BUS;
      if (readNotWrite) begin
         case (rd_region)
            REG_LOW:  dataBusInput = low_mem[addr[LOW_BITS-1:0]];
            REG_PROG: dataBusInput = prog_mem[addr[PROG_BITS-1:0]];
            REG_VEC:  dataBusInput = vec_mem[vec_index(addr)];
            default:  dataBusInput = OPEN_BUS;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && wr_region == REG_LOW) begin
         low_mem[wr_addr[LOW_BITS-1:0]] <= wr_data;
      end
      if (wr_en && wr_region == REG_PROG) begin
         prog_mem[wr_addr[PROG_BITS-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         vec_mem[0] <= NMI_VEC[7:0];
         vec_mem[1] <= NMI_VEC[15:8];
         vec_mem[2] <= RST_VEC[7:0];
         vec_mem[3] <= RST_VEC[15:8];
         vec_mem[4] <= IRQ_VEC[7:0];
         vec_mem[5] <= IRQ_VEC[15:8];
      end else if (wr_en && wr_region == REG_VEC) begin
         vec_mem[vec_index(wr_addr)] <= wr_data;
      end
   end

`ifdef BUS_WAIT_STATES_EN
   localparam logic [2:0] WS = 3'(WAIT_STATES);

   logic [15:0] prev_addr;
   logic        prev_rnw;
   logic        prev_valid;
   logic [2:0]  cnt;
   logic        new_access;

   // An access repeated with the same address and direction continues the previous one.
   assign new_access = !prev_valid || ({addr, readNotWrite} != {prev_addr, prev_rnw});

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         prev_addr  <= 16'h0000;
         prev_rnw   <= 1'b1;
         prev_valid <= 1'b0;
         cnt        <= 3'd0;
      end else begin
         prev_addr  <= addr;
         prev_rnw   <= readNotWrite;
         prev_valid <= 1'b1;
         if (new_access) begin
            cnt <= (WS == 3'd0) ? 3'd0 : 3'd1;
         end else if (cnt < WS) begin
            cnt <= cnt + 3'd1;
         end
      end
   end

   assign ready = nrst && !load_en && ((WS == 3'd0) || (!new_access && cnt == WS));
`else
   assign ready = nrst && !load_en;
`endif

endmodule

// File: tb/tb_bus_memory8227.sv
// Self-checking bench for bus_memory8227 against a flat 64K reference memory model.
// Wait-state expectations follow BUS_WAIT_STATES_EN (2 waits when defined, none otherwise).
module tb_bus_memory8227;

`ifdef BUS_WAIT_STATES_EN
   localparam int WS = 2;
`else
   localparam int WS = 0;
`endif

   logic        clk;
   logic        nrst;
   logic [7:0]  ahi;
   logic [7:0]  alo;
   logic        rnw;
   logic [7:0]  dout;
   logic        den;
   logic [7:0]  din;
   logic        ready;
   logic        load_en;
   logic [15:0] load_addr;
   logic [7:0]  load_data;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [7:0]  ref_mem [65536];
   bit          known   [65536];
   logic [15:0] m_last;
   logic        m_last_rnw;
   bit          m_valid;

   bus_memory8227 #(.WAIT_STATES(WS)) dut (
      .clk           (clk),
      .nrst          (nrst),
      .AddressBusHigh(ahi),
      .AddressBusLow (alo),
      .readNotWrite  (rnw),
      .dataBusOutput (dout),
      .dataBusEnable (den),
      .dataBusInput  (din),
      .ready         (ready),
      .load_en       (load_en),
      .load_addr     (load_addr),
      .load_data     (load_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit mapped(input logic [15:0] a);
      return (a < 16'h0800) || (a >= 16'hCC00 && a <= 16'hCCFF) || (a >= 16'hFFFA);
   endfunction

   task automatic model_reset_vectors();
      ref_mem[16'hFFFA] = 8'h00; ref_mem[16'hFFFB] = 8'h00;
      ref_mem[16'hFFFC] = 8'hDD; ref_mem[16'hFFFD] = 8'hCC;
      ref_mem[16'hFFFE] = 8'h00; ref_mem[16'hFFFF] = 8'h00;
      for (int i = 16'hFFFA; i <= 16'hFFFF; i++) known[i] = 1'b1;
   endtask

   // Entered just after a rising edge; returns just after the edge that completes the access.
   task automatic cpu_access(input logic [15:0] a, input bit r, input logic [7:0] d,
                             input bit en, input string name);
      int waits;
      bit is_new;
      logic [7:0] exp_d;
      ahi = a[15:8]; alo = a[7:0]; rnw = r; dout = d; den = en;
      is_new = !m_valid || (a != m_last) || (r != m_last_rnw);
      waits = is_new ? WS : 0;
      for (int k = 0; k <= waits; k++) begin
         @(negedge clk);
         total_cnt++;
         if (ready !== (k == waits)) begin
            $display("FAIL %s ready cycle %0d: got %b want %b", name, k, ready, (k == waits));
         end else begin
            pass_cnt++;
         end
         if (k == waits && (!r || !mapped(a) || known[a])) begin
            exp_d = (r && mapped(a)) ? ref_mem[a] : 8'hFF;
            total_cnt++;
            if (din !== exp_d) begin
               $display("FAIL %s data @%h: got %h want %h", name, a, din, exp_d);
            end else begin
               pass_cnt++;
            end
         end
         @(posedge clk); #1;
      end
      if (!r && en && mapped(a)) begin
         ref_mem[a] = d;
         known[a] = 1'b1;
      end
      den = 1'b0;
      m_last = a; m_last_rnw = r; m_valid = 1'b1;
   endtask

   task automatic load(input logic [15:0] a, input logic [7:0] d, input string name);
      load_en = 1'b1; load_addr = a; load_data = d;
      @(negedge clk);
      total_cnt++;
      if (ready !== 1'b0) begin
         $display("FAIL %s ready during load: got %b want 0", name, ready);
      end else begin
         pass_cnt++;
      end
      @(posedge clk); #1;
      load_en = 1'b0;
      if (mapped(a)) begin
         ref_mem[a] = d;
         known[a] = 1'b1;
      end
      m_last = {ahi, alo}; m_last_rnw = rnw; m_valid = 1'b1;
   endtask

   task automatic test_reset();
      nrst = 1'b0; ahi = 8'hFF; alo = 8'hFC; rnw = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready);
      else pass_cnt++;
      total_cnt++;
      if (din !== 8'hDD) $display("FAIL reset_vector: got %h want dd", din);
      else pass_cnt++;
      @(posedge clk); #1;
      nrst = 1'b1;
      m_valid = 1'b0;
      model_reset_vectors();
   endtask

   task automatic test_vectors();
      cpu_access(16'hFFFC, 1'b1, 8'h00, 1'b0, "vec_fffc");
      cpu_access(16'hFFFD, 1'b1, 8'h00, 1'b0, "vec_fffd");
      cpu_access(16'hFFFA, 1'b1, 8'h00, 1'b0, "vec_fffa");
      cpu_access(16'hFFFF, 1'b1, 8'h00, 1'b0, "vec_ffff");
   endtask

   task automatic test_loader();
      load(16'hCCDD, 8'hA9, "load_ccdd");
      cpu_access(16'hCCDD, 1'b1, 8'h00, 1'b0, "rd_ccdd");
      load(16'hCC00, 8'h11, "load_cc00");
      load(16'hCCFF, 8'h22, "load_ccff");
      load(16'h07FF, 8'h33, "load_07ff");
      load(16'h0000, 8'h44, "load_0000");
      load(16'h4000, 8'h55, "load_4000");
      cpu_access(16'hCC00, 1'b1, 8'h00, 1'b0, "rd_cc00");
      cpu_access(16'hCCFF, 1'b1, 8'h00, 1'b0, "rd_ccff");
      cpu_access(16'h07FF, 1'b1, 8'h00, 1'b0, "rd_07ff");
      cpu_access(16'h0000, 1'b1, 8'h00, 1'b0, "rd_0000");
      cpu_access(16'h4000, 1'b1, 8'h00, 1'b0, "rd_4000_after_load");
   endtask

   task automatic test_cpu_write();
      cpu_access(16'h01FF, 1'b0, 8'h19, 1'b1, "wr_01ff");
      cpu_access(16'h01FF, 1'b1, 8'h00, 1'b0, "rd_01ff");
      cpu_access(16'h01FF, 1'b0, 8'h77, 1'b0, "wr_01ff_no_enable");
      cpu_access(16'h01FF, 1'b1, 8'h00, 1'b0, "rd_01ff_kept");
      cpu_access(16'h4000, 1'b0, 8'h66, 1'b1, "wr_4000");
      cpu_access(16'h4000, 1'b1, 8'h00, 1'b0, "rd_4000");
      cpu_access(16'hFFFE, 1'b0, 8'h5A, 1'b1, "wr_fffe");
      cpu_access(16'hFFFE, 1'b1, 8'h00, 1'b0, "rd_fffe");
   endtask

   task automatic test_boundaries();
      cpu_access(16'h0800, 1'b0, 8'h12, 1'b1, "wr_0800");
      cpu_access(16'h0800, 1'b1, 8'h00, 1'b0, "rd_0800");
      cpu_access(16'hCBFF, 1'b1, 8'h00, 1'b0, "rd_cbff");
      cpu_access(16'hCD00, 1'b1, 8'h00, 1'b0, "rd_cd00");
      cpu_access(16'hFFF9, 1'b1, 8'h00, 1'b0, "rd_fff9");
      cpu_access(16'hCCFF, 1'b0, 8'hE7, 1'b1, "wr_ccff");
      cpu_access(16'hCCFF, 1'b1, 8'h00, 1'b0, "rd_ccff_cpu");
   endtask

   task automatic test_back_to_back();
      cpu_access(16'h0010, 1'b0, 8'h3C, 1'b1, "wr_0010");
      cpu_access(16'h0011, 1'b0, 8'hC3, 1'b1, "wr_0011");
      cpu_access(16'h0010, 1'b1, 8'h00, 1'b0, "rd_0010");
      cpu_access(16'h0011, 1'b1, 8'h00, 1'b0, "rd_0011");
      cpu_access(16'h0011, 1'b1, 8'h00, 1'b0, "rd_0011_repeat");
   endtask

   task automatic test_random();
      logic [15:0] pool [14];
      logic [15:0] a;
      logic [7:0]  d;
      int op;
      pool = '{16'h0000, 16'h0010, 16'h01FF, 16'h07FF, 16'h0800, 16'hCBFF, 16'hCC00,
               16'hCC80, 16'hCCFF, 16'hCD00, 16'h4000, 16'hFFF9, 16'hFFFB, 16'hFFFE};
      for (int i = 0; i < 60; i++) begin
         a  = pool[$urandom_range(0, 13)];
         d  = 8'($urandom);
         op = $urandom_range(0, 3);
         case (op)
            0: load(a, d, $sformatf("rnd%0d_load", i));
            1: cpu_access(a, 1'b0, d, ($urandom_range(0, 3) != 0), $sformatf("rnd%0d_wr", i));
            default: cpu_access(a, 1'b1, 8'h00, 1'b0, $sformatf("rnd%0d_rd", i));
         endcase
      end
   endtask

   task automatic test_reset_mid_wait();
      ahi = 8'h00; alo = 8'h20; rnw = 1'b1; den = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (ready !== (WS == 0)) $display("FAIL midwait_first: got %b want %b", ready, (WS == 0));
      else pass_cnt++;
      @(posedge clk); #1;
      nrst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (ready !== 1'b0) $display("FAIL midwait_in_reset: got %b want 0", ready);
      else pass_cnt++;
      @(posedge clk); #1;
      nrst = 1'b1;
      m_valid = 1'b0;
      model_reset_vectors();
      cpu_access(16'h0020, 1'b1, 8'h00, 1'b0, "after_reset_0020");
      cpu_access(16'hFFFC, 1'b1, 8'h00, 1'b0, "after_reset_fffc");
      cpu_access(16'hFFFD, 1'b1, 8'h00, 1'b0, "after_reset_fffd");
      cpu_access(16'hFFFE, 1'b1, 8'h00, 1'b0, "after_reset_fffe");
   endtask

   initial begin
      nrst = 1'b0; ahi = 8'h00; alo = 8'h00; rnw = 1'b1; dout = 8'h00; den = 1'b0;
      load_en = 1'b0; load_addr = 16'h0000; load_data = 8'h00;
      m_last = 16'h0000; m_last_rnw = 1'b1; m_valid = 1'b0;
      for (int i = 0; i < 65536; i++) known[i] = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_vectors();
      test_loader();
      test_cpu_write();
      test_boundaries();
      test_back_to_back();
      test_random();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
